busmatrix_input_hold_stage: RTL and testbench

- Per-master input stage of the 5x7 AHB bus matrix, one instance per slave-side port.
- Sits directly upstream of the per-slave output arbiters and feeds each arbiter's req_portN.
- When an arbiter does not grant the port, the stage registers the master's address phase, stalls the master with HREADYOUTS low, and replays the held transfer from the register once granted.
- Tracks the port's outstanding data phase and returns the slave's ready/response to the master.

---
 rtl/busmatrix_input_hold_stage.sv | 146 ++++++++++++++
 tb/tb_busmatrix_input_hold_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/busmatrix_input_hold_stage.sv
// Per-master input stage of the AHB bus matrix: holds an address phase the
// arbiters did not grant, stalls the master, and replays it once granted.
module busmatrix_input_hold_stage #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSELS,
    input  logic [ADDR_WIDTH-1:0] HADDRS,
    input  logic [1:0]            HTRANSS,
    input  logic                  HWRITES,
    input  logic [2:0]            HSIZES,
    input  logic [2:0]            HBURSTS,
    input  logic [3:0]            HPROTS,
    input  logic                  HMASTLOCKS,
    input  logic                  HREADYS,
    input  logic                  active_trans,
    input  logic                  HREADYOUTM,
    input  logic                  HRESPM,
    output logic                  sel_out,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [1:0]            trans_out,
    output logic                  write_out,
    output logic [2:0]            size_out,
    output logic [2:0]            burst_out,
    output logic [3:0]            prot_out,
    output logic                  mastlock_out,
    output logic                  req_port,
    output logic                  HREADYOUTS,
    output logic                  HRESPS
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [1:0]              trans_reg;
    logic                    write_reg;
    logic [2:0]              size_reg;
    logic [2:0]              burst_reg;
    logic [3:0]              prot_reg;
    logic                    mastlock_reg;

    logic                    trans_valid;
    logic                    capture;

    // Only NONSEQ/SEQ transfers that the master is actually issuing count.
    assign trans_valid = HSELS & HTRANSS[1] & HREADYS;

    always_comb begin
        capture = 1'b0;
        case (state_reg)
            ST_IDLE: capture = trans_valid & ~active_trans;
            ST_DATA: capture = HREADYOUTM & trans_valid & ~active_trans;
            default: capture = 1'b0;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= '0;
            trans_reg    <= '0;
            write_reg    <= 1'b0;
            size_reg     <= '0;
            burst_reg    <= '0;
            prot_reg     <= '0;
            mastlock_reg <= 1'b0;
        end else begin
            if (capture) begin
                addr_reg     <= HADDRS;
                trans_reg    <= HTRANSS;
                write_reg    <= HWRITES;
                size_reg     <= HSIZES;
                burst_reg    <= HBURSTS;
                prot_reg     <= HPROTS;
                mastlock_reg <= HMASTLOCKS;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (trans_valid)
                        state_reg <= active_trans ? ST_DATA : ST_PEND;
                end
                ST_PEND: begin
                    if (active_trans)
                        state_reg <= ST_DATA;
                end
                ST_DATA: begin
                    if (HREADYOUTM) begin
                        if (!trans_valid)
                            state_reg <= ST_IDLE;
                        else if (!active_trans)
                            state_reg <= ST_PEND;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // While pending, the arbiters see the held transfer; otherwise the live bus.
    always_comb begin
        if (state_reg == ST_PEND) begin
            sel_out      = 1'b1;
            addr_out     = addr_reg;
            trans_out    = trans_reg;
            write_out    = write_reg;
            size_out     = size_reg;
            burst_out    = burst_reg;
            prot_out     = prot_reg;
            mastlock_out = mastlock_reg;
        end else begin
            sel_out      = HSELS;
            addr_out     = HADDRS;
            trans_out    = HTRANSS;
            write_out    = HWRITES;
            size_out     = HSIZES;
            burst_out    = HBURSTS;
            prot_out     = HPROTS;
            mastlock_out = HMASTLOCKS;
        end
    end

    assign req_port = sel_out & trans_out[1];

    always_comb begin
        HREADYOUTS = 1'b1;
        HRESPS     = 1'b0;
        case (state_reg)
            ST_PEND: HREADYOUTS = 1'b0;
            ST_DATA: begin
                HREADYOUTS = HREADYOUTM;
                HRESPS     = HRESPM;
            end
            default: begin
                HREADYOUTS = 1'b1;
                HRESPS     = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_busmatrix_input_hold_stage.sv
// Directed bench for busmatrix_input_hold_stage with a transaction-level model
// (held-transfer flag + outstanding-data-phase flag) checked every cycle.
module tb_busmatrix_input_hold_stage;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        HSELS = 1'b0;
    logic [31:0] HADDRS = '0;
    logic [1:0]  HTRANSS = T_IDLE;
    logic        HWRITES = 1'b0;
    logic [2:0]  HSIZES = 3'd2;
    logic [2:0]  HBURSTS = 3'd0;
    logic [3:0]  HPROTS = 4'h3;
    logic        HMASTLOCKS = 1'b0;
    logic        HREADYS = 1'b1;
    logic        active_trans = 1'b0;
    logic        HREADYOUTM = 1'b1;
    logic        HRESPM = 1'b0;

    logic        sel_out, write_out, mastlock_out, req_port, HREADYOUTS, HRESPS;
    logic [31:0] addr_out;
    logic [1:0]  trans_out;
    logic [2:0]  size_out, burst_out;
    logic [3:0]  prot_out;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    busmatrix_input_hold_stage #(.ADDR_WIDTH(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSELS(HSELS), .HADDRS(HADDRS),
        .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
        .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS),
        .active_trans(active_trans), .HREADYOUTM(HREADYOUTM), .HRESPM(HRESPM),
        .sel_out(sel_out), .addr_out(addr_out), .trans_out(trans_out),
        .write_out(write_out), .size_out(size_out), .burst_out(burst_out),
        .prot_out(prot_out), .mastlock_out(mastlock_out), .req_port(req_port),
        .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS)
    );

    always #5 HCLK = ~HCLK;

    // Model: a held transfer (stall, replay) and an outstanding data phase.
    bit          m_held = 1'b0;
    bit          m_busy = 1'b0;
    logic [31:0] m_addr = '0;
    logic [1:0]  m_trans = '0;
    logic        m_write = 1'b0;
    logic [2:0]  m_size = '0;
    logic [2:0]  m_burst = '0;
    logic [3:0]  m_prot = '0;
    logic        m_lock = 1'b0;

    always @(posedge HCLK) begin
        if (HRESET) begin
            m_held <= 1'b0;
            m_busy <= 1'b0;
        end else if (m_held) begin
            if (active_trans) begin
                m_held <= 1'b0;
                m_busy <= 1'b1;
            end
        end else if (!m_busy || HREADYOUTM) begin
            if (HSELS && HTRANSS[1] && HREADYS) begin
                if (active_trans) begin
                    m_busy <= 1'b1;
                end else begin
                    m_held  <= 1'b1;
                    m_busy  <= 1'b0;
                    m_addr  <= HADDRS;
                    m_trans <= HTRANSS;
                    m_write <= HWRITES;
                    m_size  <= HSIZES;
                    m_burst <= HBURSTS;
                    m_prot  <= HPROTS;
                    m_lock  <= HMASTLOCKS;
                end
            end else begin
                m_busy <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    always @(negedge HCLK) begin
        if (chk_en) begin
            #1;
            chk("sel_out",      {31'd0, sel_out},      {31'd0, m_held ? 1'b1 : HSELS});
            chk("addr_out",     addr_out,              m_held ? m_addr : HADDRS);
            chk("trans_out",    {30'd0, trans_out},    {30'd0, m_held ? m_trans : HTRANSS});
            chk("write_out",    {31'd0, write_out},    {31'd0, m_held ? m_write : HWRITES});
            chk("size_out",     {29'd0, size_out},     {29'd0, m_held ? m_size : HSIZES});
            chk("burst_out",    {29'd0, burst_out},    {29'd0, m_held ? m_burst : HBURSTS});
            chk("prot_out",     {28'd0, prot_out},     {28'd0, m_held ? m_prot : HPROTS});
            chk("mastlock_out", {31'd0, mastlock_out}, {31'd0, m_held ? m_lock : HMASTLOCKS});
            chk("req_port",     {31'd0, req_port},
                {31'd0, m_held ? m_trans[1] : (HSELS & HTRANSS[1])});
            chk("HREADYOUTS",   {31'd0, HREADYOUTS},
                {31'd0, m_held ? 1'b0 : (m_busy ? HREADYOUTM : 1'b1)});
            chk("HRESPS",       {31'd0, HRESPS},       {31'd0, (!m_held && m_busy) ? HRESPM : 1'b0});
        end
    end

    // One bus cycle: drive just after the rising edge, model compare at the falling edge.
    task automatic cyc(input logic rst, input logic sel, input logic [31:0] addr,
                       input logic [1:0] trans, input logic wr, input logic at,
                       input logic rdy, input logic resp, input logic hrdys);
        @(posedge HCLK);
        #1;
        HRESET = rst; HSELS = sel; HADDRS = addr; HTRANSS = trans; HWRITES = wr;
        active_trans = at; HREADYOUTM = rdy; HRESPM = resp; HREADYS = hrdys;
        @(negedge HCLK);
        #2;
        $display("cyc t=%0t rst=%0b sel=%0b addr=%h trans=%0d at=%0b rdym=%0b -> addr_out=%h req=%0b rdy=%0b resp=%0b",
                 $time, rst, sel, addr, trans, at, rdy, addr_out, req_port, HREADYOUTS, HRESPS);
    endtask

    initial begin
        cyc(1, 0, 32'h0, T_IDLE, 0, 0, 1, 0, 1);
        chk_en = 1'b1;
        cyc(1, 0, 32'h0, T_IDLE, 0, 0, 1, 0, 1);
        chk("reset_readyout", {31'd0, HREADYOUTS}, 32'd1);
        chk("reset_resp",     {31'd0, HRESPS},     32'd0);

        // Immediate grant
        cyc(0, 1, 32'h2000_0000, T_NSEQ, 0, 1, 1, 0, 1);
        chk("grant_addr_ready", {31'd0, HREADYOUTS}, 32'd1);
        chk("grant_req",        {31'd0, req_port},   32'd1);
        cyc(0, 0, 32'h0, T_IDLE, 0, 0, 0, 0, 0);
        chk("grant_data_wait",  {31'd0, HREADYOUTS}, 32'd0);
        cyc(0, 0, 32'h0, T_IDLE, 0, 0, 1, 0, 1);
        chk("grant_data_done",  {31'd0, HREADYOUTS}, 32'd1);

        // Held transfer: master moves its bus while stalled; held values must persist
        cyc(0, 1, 32'h4000_0010, T_NSEQ, 1, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 32'h5555_0000 + i, T_SEQ, 0, 0, 1, 0, 0);
            chk("held_ready", {31'd0, HREADYOUTS}, 32'd0);
            chk("held_addr",  addr_out,            32'h4000_0010);
            chk("held_req",   {31'd0, req_port},   32'd1);
            chk("held_write", {31'd0, write_out},  32'd1);
        end
        cyc(0, 0, 32'h5555_0000, T_IDLE, 0, 1, 1, 0, 0);
        chk("held_grant_addr", addr_out, 32'h4000_0010);
        cyc(0, 0, 32'h0, T_IDLE, 0, 0, 1, 0, 1);
        chk("held_data_ready", {31'd0, HREADYOUTS}, 32'd1);

        // INCR4 with one wait state per beat
        HBURSTS = 3'b011; HMASTLOCKS = 1'b1;
        cyc(0, 1, 32'h0000_1000, T_NSEQ, 0, 1, 1, 0, 1);
        for (int b = 1; b < 4; b++) begin
            cyc(0, 1, 32'h0000_1000 + 4 * b, T_SEQ, 0, 0, 0, 0, 0);
            chk("incr_wait", {31'd0, HREADYOUTS}, 32'd0);
            cyc(0, 1, 32'h0000_1000 + 4 * b, T_SEQ, 0, 1, 1, 0, 1);
            chk("incr_beat", {31'd0, HREADYOUTS}, 32'd1);
        end
        cyc(0, 0, 32'h0, T_IDLE, 0, 0, 0, 0, 0);
        chk("incr_last_wait", {31'd0, HREADYOUTS}, 32'd0);
        cyc(0, 0, 32'h0, T_IDLE, 0, 0, 1, 0, 1);
        HBURSTS = 3'd0; HMASTLOCKS = 1'b0;

        // Capture from DATA
        cyc(0, 1, 32'h1000_0000, T_NSEQ, 0, 1, 1, 0, 1);
        cyc(0, 1, 32'h3000_0040, T_NSEQ, 0, 0, 1, 0, 1);
        chk("cap_resp",  {31'd0, HRESPS},     32'd0);
        cyc(0, 1, 32'h7777_0000, T_NSEQ, 0, 0, 1, 0, 0);
        chk("cap_addr",  addr_out,            32'h3000_0040);
        chk("cap_ready", {31'd0, HREADYOUTS}, 32'd0);
        cyc(0, 0, 32'h0, T_IDLE, 0, 1, 1, 0, 0);
        cyc(0, 0, 32'h0, T_IDLE, 0, 0, 1, 0, 1);

        // Two-cycle ERROR
        cyc(0, 1, 32'h2000_0100, T_NSEQ, 0, 1, 1, 0, 1);
        cyc(0, 0, 32'h0, T_IDLE, 0, 0, 0, 1, 0);
        chk("err1_resp",  {31'd0, HRESPS},     32'd1);
        chk("err1_ready", {31'd0, HREADYOUTS}, 32'd0);
        cyc(0, 0, 32'h0, T_IDLE, 0, 0, 1, 1, 1);
        chk("err2_resp",  {31'd0, HRESPS},     32'd1);
        chk("err2_ready", {31'd0, HREADYOUTS}, 32'd1);

        // Not-ready master bus: nothing captured
        cyc(0, 1, 32'h0BAD_0000, T_NSEQ, 0, 0, 1, 0, 0);
        cyc(0, 0, 32'h0, T_IDLE, 0, 0, 1, 0, 1);
        chk("noready_idle", {31'd0, HREADYOUTS}, 32'd1);

        // Reset while pending drops the held transfer
        cyc(0, 1, 32'h6000_0000, T_NSEQ, 0, 0, 1, 0, 1);
        cyc(1, 0, 32'h0, T_IDLE, 0, 0, 1, 0, 0);
        chk("rstpend_ready", {31'd0, HREADYOUTS}, 32'd0);
        cyc(0, 1, 32'h7000_0000, T_IDLE, 0, 0, 1, 0, 1);
        chk("rstpend_after_ready", {31'd0, HREADYOUTS}, 32'd1);
        chk("rstpend_after_req",   {31'd0, req_port},   32'd0);
        chk("rstpend_after_addr",  addr_out,            32'h7000_0000);
        cyc(0, 0, 32'h0, T_IDLE, 0, 0, 1, 0, 1);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
